// File: rtl/eth_pkg.sv
// Shared constants, types and helpers for the Ethernet/IPv4/UDP frame path.
//  - eth_udp_length_width : width of the UDP payload length field
//  - header length constants, EtherType / protocol codes, minimum frame length
//  - udp_fb_state_e       : frame builder FSM states
//  - ones_fold()          : folds a 20-bit one's-complement sum down to 16 bits
package eth_pkg;

    localparam int eth_udp_length_width = 16;

    localparam int ETH_HDR_LEN       = 14;
    localparam int IPV4_HDR_LEN      = 20;
    localparam int UDP_HDR_LEN       = 8;
    localparam int ETH_MIN_FRAME_LEN = 60;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    // Number of 16-bit words summed for the IPv4 header checksum.
    localparam int CSUM_WORDS = 10;

    // Frame byte position must cover 42 header bytes plus a 16-bit payload length.
    localparam int FRAME_POS_WIDTH = 17;

    typedef logic [eth_udp_length_width-1:0] udp_len_t;
    typedef logic [FRAME_POS_WIDTH-1:0]      frame_pos_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSUM,
        S_HEADER,
        S_PAYLOAD,
        S_PAD
    } udp_fb_state_e;

    // Two end-around-carry folds. After the first fold the value is at most 0x1000E, so the
    // second fold cannot carry out again.
    function automatic logic [15:0] ones_fold(input logic [19:0] acc);
        logic [16:0] s1;
        logic [15:0] s2;
        s1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        s2 = s1[15:0] + {15'd0, s1[16]};
        return s2;
    endfunction

endpackage

// File: rtl/eth_ip_checksum.sv
// Serial IPv4 header checksum: one 16-bit word per cycle into a 20-bit accumulator.
// Ports:
//  Clk, Rst_n : clock, asynchronous active-low reset
//  start      : clears the accumulator and word count
//  word       : 16-bit header word
//  valid      : add word this cycle
//  csum       : inverted folded sum of the words accumulated so far
//  done       : all CSUM_WORDS words have been accumulated
module eth_ip_checksum
    import eth_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic [15:0] word,
    input  logic        valid,
    output logic [15:0] csum,
    output logic        done
);

    logic [19:0] acc_q;
    logic [3:0]  cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (valid) begin
            acc_q <= acc_q + {4'd0, word};
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign csum = ~ones_fold(acc_q);
    assign done = (cnt_q == 4'(CSUM_WORDS));

endmodule

// File: rtl/udp_frame_builder.sv
// Wraps a byte-wide UDP payload stream into an Ethernet II / IPv4 / UDP frame (no FCS).
// A 42-byte header with computed IPv4 checksum is prepended; UDP checksum is sent as 0.
// Ports:
//  Clk, Rst_n    : clock, asynchronous active-low reset
//  Udp_length    : payload byte count, sampled on the first Udp_valid of a frame
//  Udp_data/Udp_valid/Udp_last/Udp_ready : payload stream in
//  Mac_data/Mac_valid/Mac_last/Mac_ready : frame stream out
//  Length_error  : one-cycle pulse when Udp_last disagrees with Udp_length (once per frame)
// Configuration:
//  UDP_FRAME_MIN_PAD_EN : when defined, short frames are zero-padded up to 60 bytes.
module udp_frame_builder
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC  = 48'h0200_0000_0001,
    parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
    parameter logic [31:0] DST_IP   = 32'hC0A8_0002,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001,
    parameter logic [7:0]  IP_TTL   = 8'd64
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic [eth_udp_length_width-1:0] Udp_length,
    input  logic [7:0]                      Udp_data,
    input  logic                            Udp_valid,
    input  logic                            Udp_last,
    output logic                            Udp_ready,
    output logic [7:0]                      Mac_data,
    output logic                            Mac_valid,
    output logic                            Mac_last,
    input  logic                            Mac_ready,
    output logic                            Length_error
);

    localparam int         HdrLen     = ETH_HDR_LEN + IPV4_HDR_LEN + UDP_HDR_LEN;
    localparam frame_pos_t HdrLastPos = frame_pos_t'(HdrLen - 1);
    localparam frame_pos_t PadLastPos = frame_pos_t'(ETH_MIN_FRAME_LEN - 1);
    localparam frame_pos_t CsumWords  = frame_pos_t'(CSUM_WORDS);

    udp_fb_state_e state_q;
    udp_len_t      len_q;
    logic [15:0]   ip_id_q;
    logic [15:0]   csum_q;
    // Byte position within the frame; doubles as the checksum word index in S_CSUM.
    frame_pos_t    pos_q;
    udp_len_t      pay_cnt_q;
    logic          err_seen_q;
    logic          len_err_q;

    logic [15:0]   ip_total_len;
    logic [15:0]   udp_total_len;
    logic [15:0]   csum_word;
    logic          csum_start;
    logic          csum_valid;
    logic [15:0]   csum_val;
    logic          csum_done;
    logic [335:0]  hdr_vec;
    logic [335:0]  hdr_shift;
    udp_len_t      pay_next;
    logic          len_mismatch;
    logic          pad_pending;

    assign ip_total_len  = len_q + 16'(IPV4_HDR_LEN + UDP_HDR_LEN);
    assign udp_total_len = len_q + 16'(UDP_HDR_LEN);

    assign csum_start = (state_q == S_IDLE) && Udp_valid;
    assign csum_valid = (state_q == S_CSUM) && (pos_q < CsumWords);

    always_comb begin
        csum_word = 16'h0000;
        case (pos_q[3:0])
            4'd0:    csum_word = 16'h4500;
            4'd1:    csum_word = ip_total_len;
            4'd2:    csum_word = ip_id_q;
            4'd3:    csum_word = 16'h4000;
            4'd4:    csum_word = {IP_TTL, IP_PROTO_UDP};
            4'd5:    csum_word = 16'h0000;
            4'd6:    csum_word = SRC_IP[31:16];
            4'd7:    csum_word = SRC_IP[15:0];
            4'd8:    csum_word = DST_IP[31:16];
            4'd9:    csum_word = DST_IP[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    eth_ip_checksum u_csum (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (csum_start),
        .word  (csum_word),
        .valid (csum_valid),
        .csum  (csum_val),
        .done  (csum_done)
    );

    // Whole header as one vector, byte 0 in the top bits; selected by shifting left.
    assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, 8'h45, 8'h00, ip_total_len, ip_id_q,
                      16'h4000, IP_TTL, IP_PROTO_UDP, csum_q, SRC_IP, DST_IP, SRC_PORT,
                      DST_PORT, udp_total_len, 16'h0000};
    assign hdr_shift = hdr_vec << {pos_q[5:0], 3'b000};

    assign pay_next     = pay_cnt_q + 1'b1;
    assign len_mismatch = Udp_last ? (pay_next != len_q) : (pay_next == len_q);

`ifdef UDP_FRAME_MIN_PAD_EN
    // pos_q is the position of the byte being sent; frame is short if pos_q+1 < 60.
    assign pad_pending = ((pos_q + 1'b1) < frame_pos_t'(ETH_MIN_FRAME_LEN));
`else
    assign pad_pending = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            ip_id_q    <= '0;
            csum_q     <= '0;
            pos_q      <= '0;
            pay_cnt_q  <= '0;
            err_seen_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // First payload byte is only observed here, consumed later in S_PAYLOAD.
                    if (Udp_valid) begin
                        len_q      <= Udp_length;
                        pos_q      <= '0;
                        err_seen_q <= 1'b0;
                        state_q    <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (pos_q < CsumWords) begin
                        pos_q <= pos_q + 1'b1;
                    end else if (csum_done) begin
                        csum_q  <= csum_val;
                        pos_q   <= '0;
                        state_q <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (Mac_ready) begin
                        pos_q <= pos_q + 1'b1;
                        if (pos_q == HdrLastPos) begin
                            pay_cnt_q <= '0;
                            state_q   <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (Udp_valid && Mac_ready) begin
                        pos_q     <= pos_q + 1'b1;
                        pay_cnt_q <= pay_next;
                        if (len_mismatch && !err_seen_q) begin
                            len_err_q  <= 1'b1;
                            err_seen_q <= 1'b1;
                        end
                        if (Udp_last) begin
                            if (pad_pending) begin
                                state_q <= S_PAD;
                            end else begin
                                state_q <= S_IDLE;
                                ip_id_q <= ip_id_q + 16'd1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (Mac_ready) begin
                        if (pos_q == PadLastPos) begin
                            state_q <= S_IDLE;
                            ip_id_q <= ip_id_q + 16'd1;
                        end else begin
                            pos_q <= pos_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Payload is a zero-latency pass-through, so the stream outputs are decoded from state.
    always_comb begin
        Udp_ready = 1'b0;
        Mac_valid = 1'b0;
        Mac_data  = 8'h00;
        Mac_last  = 1'b0;
        unique case (state_q)
            S_HEADER: begin
                Mac_valid = 1'b1;
                Mac_data  = hdr_shift[335:328];
            end
            S_PAYLOAD: begin
                Mac_valid = Udp_valid;
                Mac_data  = Udp_data;
                Udp_ready = Mac_ready;
                Mac_last  = Udp_last && !pad_pending;
            end
            S_PAD: begin
                Mac_valid = 1'b1;
                Mac_last  = (pos_q == PadLastPos);
            end
            default: begin
                Mac_valid = 1'b0;
            end
        endcase
    end

    assign Length_error = len_err_q;

endmodule

// File: tb/tb_udp_frame_builder.sv
module tb_udp_frame_builder;

    localparam logic [47:0] T_DST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] T_SRC_MAC = 48'h0200_0000_0001;
    localparam logic [31:0] T_SRC_IP  = 32'hC0A8_0001;
    localparam logic [31:0] T_DST_IP  = 32'hC0A8_0002;

`ifdef UDP_FRAME_MIN_PAD_EN
    localparam int T1_LEN = 60;
    localparam int T4_LEN = 60;
    localparam int T6_LEN = 60;
`else
    localparam int T1_LEN = 46;
    localparam int T4_LEN = 45;
    localparam int T6_LEN = 43;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [15:0] Udp_length = '0;
    logic [7:0]  Udp_data = '0;
    logic        Udp_valid = 1'b0;
    logic        Udp_last = 1'b0;
    logic        Udp_ready;
    logic [7:0]  Mac_data;
    logic        Mac_valid;
    logic        Mac_last;
    logic        Mac_ready = 1'b0;
    logic        Length_error;

    always #5 Clk = ~Clk;

    udp_frame_builder dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Udp_length   (Udp_length),
        .Udp_data     (Udp_data),
        .Udp_valid    (Udp_valid),
        .Udp_last     (Udp_last),
        .Udp_ready    (Udp_ready),
        .Mac_data     (Mac_data),
        .Mac_valid    (Mac_valid),
        .Mac_last     (Mac_last),
        .Mac_ready    (Mac_ready),
        .Length_error (Length_error)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  exp_d[$];
    logic        exp_l[$];
    logic [7:0]  cur[$];
    logic [7:0]  last_frame[$];
    logic [15:0] ids[$];
    logic [15:0] csums[$];
    int          frames_done = 0;
    int          err_pulses = 0;
    bit          rand_rdy = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  pl[300];
    logic [15:0] model_id = '0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // IPv4 header checksum straight from the header fields.
    function automatic logic [15:0] ip_csum(input int len, input logic [15:0] id);
        int unsigned s;
        s = 32'h4500 + ((len + 28) & 32'hFFFF) + id + 32'h4000 + 32'h4011
            + T_SRC_IP[31:16] + T_SRC_IP[15:0] + T_DST_IP[31:16] + T_DST_IP[15:0];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic push_n(input logic [47:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            exp_d.push_back(v[8*k +: 8]);
            exp_l.push_back(1'b0);
        end
    endtask

    // Expected byte stream for one frame carrying nbytes of pl[] and claiming length len.
    task automatic model_frame(input int len, input int nbytes, input logic [15:0] id);
        int start;
        start = exp_d.size();
        push_n(T_DST_MAC, 6);
        push_n(T_SRC_MAC, 6);
        push_n(48'h0800, 2);
        push_n(48'h45, 1);
        push_n(48'h00, 1);
        push_n(48'((len + 28) & 16'hFFFF), 2);
        push_n({32'd0, id}, 2);
        push_n(48'h4000, 2);
        push_n(48'd64, 1);
        push_n(48'h11, 1);
        push_n({32'd0, ip_csum(len, id)}, 2);
        push_n({16'd0, T_SRC_IP}, 4);
        push_n({16'd0, T_DST_IP}, 4);
        push_n(48'd5000, 2);
        push_n(48'd5001, 2);
        push_n(48'((len + 8) & 16'hFFFF), 2);
        push_n(48'h0000, 2);
        for (int i = 0; i < nbytes; i++) push_n({40'd0, pl[i]}, 1);
`ifdef UDP_FRAME_MIN_PAD_EN
        while (exp_d.size() - start < 60) push_n(48'h0, 1);
`endif
        exp_l[exp_l.size() - 1] = 1'b1;
    endtask

    // Drives one frame; abort_at >= 0 pulls reset while that payload byte is presented.
    task automatic send_frame(input int len, input int nbytes, input int abort_at);
        bit hs;
        int guard;
        Udp_length = 16'(len);
        for (int i = 0; i < nbytes; i++) begin
            Udp_valid = 1'b1;
            Udp_data  = pl[i];
            Udp_last  = (i == nbytes - 1);
            if (i == abort_at) begin
                Udp_last = 1'b0;
                #2;
                Rst_n = 1'b0;
                #1;
                chk("abort_udp_ready", Udp_ready, 0);
                chk("abort_mac_valid", Mac_valid, 0);
                chk("abort_mac_data", Mac_data, 0);
                chk("abort_mac_last", Mac_last, 0);
                exp_d.delete();
                exp_l.delete();
                Udp_valid = 1'b0;
                repeat (2) @(posedge Clk);
                #1;
                Rst_n = 1'b1;
                model_id = '0;
                return;
            end
            hs = 1'b0;
            guard = 0;
            while (!hs) begin
                @(negedge Clk);
                hs = Udp_ready;
                @(posedge Clk);
                #1;
                guard++;
                if (guard > 3000) begin
                    chk("udp_handshake_timeout", 1, 0);
                    Udp_valid = 1'b0;
                    Udp_last  = 1'b0;
                    return;
                end
            end
        end
        Udp_valid = 1'b0;
        Udp_last  = 1'b0;
    endtask

    task automatic run_frame(input int len, input int nbytes);
        model_frame(len, nbytes, model_id);
        send_frame(len, nbytes, -1);
        model_id++;
    endtask

    task automatic wait_frames(input int target);
        int g;
        g = 0;
        while (frames_done < target && g < 3000) begin
            @(posedge Clk);
            g++;
        end
        @(posedge Clk);
        #1;
        chk("frame_complete", frames_done >= target, 1);
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            Mac_ready = rand_rdy ? ($urandom_range(0, 99) < 80) : 1'b1;
        end
    end

    // Scoreboard: every accepted frame byte against the model stream.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            prev_stall = 1'b0;
            cur.delete();
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", Mac_valid, 1);
                chk("stall_data_stable", Mac_data, prev_data);
            end
            if (Mac_valid && Mac_ready) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_byte", 1, 0);
                end else begin
                    chk("mac_data", Mac_data, exp_d.pop_front());
                    chk("mac_last", Mac_last, exp_l.pop_front());
                end
                cur.push_back(Mac_data);
                if (Mac_last) begin
                    last_frame = cur;
                    if (cur.size() >= 26) begin
                        ids.push_back({cur[18], cur[19]});
                        csums.push_back({cur[24], cur[25]});
                    end
                    cur.delete();
                    frames_done++;
                end
            end
            if (Length_error) err_pulses++;
            prev_stall = Mac_valid && !Mac_ready;
            prev_data  = Mac_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int f0;
        int e0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_udp_ready", Udp_ready, 0);
        chk("rst_mac_valid", Mac_valid, 0);
        chk("rst_mac_last", Mac_last, 0);
        chk("rst_mac_data", Mac_data, 0);
        chk("rst_length_error", Length_error, 0);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // 1: len=4 DE AD BE EF, plus first-byte latency
        chk("model_csum_len4_id0", ip_csum(4, 16'h0000), 16'hB979);
        pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
        f0 = frames_done;
        model_frame(4, 4, model_id);
        fork
            send_frame(4, 4, -1);
            begin
                int k;
                k = 0;
                @(posedge Clk);
                while (k < 30) begin
                    @(posedge Clk);
                    k++;
                    @(negedge Clk);
                    if (Mac_valid) break;
                end
                chk("hdr_latency", k, 11);
            end
        join
        model_id++;
        wait_frames(f0 + 1);
        chk("t1_frame_len", last_frame.size(), T1_LEN);
        if (last_frame.size() >= 46) begin
            chk("t1_ip_len", {last_frame[16], last_frame[17]}, 16'h0020);
            chk("t1_udp_len", {last_frame[38], last_frame[39]}, 16'h000C);
            chk("t1_csum", {last_frame[24], last_frame[25]}, 16'hB979);
            chk("t1_payload", {last_frame[42], last_frame[43], last_frame[44], last_frame[45]},
                32'hDEADBEEF);
        end
`ifdef UDP_FRAME_MIN_PAD_EN
        if (last_frame.size() == 60) chk("t1_pad_zero", last_frame[59], 0);
`endif

        // 2: len=300 random payload under random backpressure
        for (int i = 0; i < 300; i++) pl[i] = 8'($urandom);
        rand_rdy = 1'b1;
        f0 = frames_done;
        run_frame(300, 300);
        wait_frames(f0 + 1);
        rand_rdy = 1'b0;
        chk("t2_frame_len", last_frame.size(), 342);
        if (last_frame.size() >= 42) begin
            chk("t2_ip_len", {last_frame[16], last_frame[17]}, 16'h0148);
            chk("t2_udp_len", {last_frame[38], last_frame[39]}, 16'h0134);
            chk("t2_ip_id", {last_frame[18], last_frame[19]}, 16'h0001);
        end
        chk("t12_no_length_error", err_pulses, 0);

        // 4: len=5 with Udp_last on the third byte
        e0 = err_pulses;
        f0 = frames_done;
        run_frame(5, 3);
        wait_frames(f0 + 1);
        chk("t4_err_pulses", err_pulses - e0, 1);
        chk("t4_frame_len", last_frame.size(), T4_LEN);
        if (last_frame.size() >= 45) begin
            chk("t4_ip_len", {last_frame[16], last_frame[17]}, 16'h0021);
            chk("t4_udp_len", {last_frame[38], last_frame[39]}, 16'h000D);
        end

        // 3: three back-to-back frames from a fresh ip_id
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        model_id = '0;
        ids.delete();
        csums.delete();
        f0 = frames_done;
        for (int i = 0; i < 8; i++) pl[i] = 8'(8'h30 + i);
        run_frame(8, 8);
        run_frame(8, 8);
        run_frame(8, 8);
        wait_frames(f0 + 3);
        chk("t3_frame_count", ids.size(), 3);
        if (ids.size() == 3) begin
            chk("t3_id0", ids[0], 16'h0000);
            chk("t3_id1", ids[1], 16'h0001);
            chk("t3_id2", ids[2], 16'h0002);
            chk("t3_csum0_ne_csum1", csums[0] != csums[1], 1);
            chk("t3_csum1_ne_csum2", csums[1] != csums[2], 1);
        end

        // 5: reset while payload byte 10 of 100 is presented
        for (int i = 0; i < 100; i++) pl[i] = 8'(i * 3 + 1);
        f0 = frames_done;
        model_frame(100, 100, model_id);
        send_frame(100, 100, 9);
        chk("t5_no_completion", frames_done, f0);
        chk("t5_len_err_after_abort", Length_error, 0);
        for (int i = 0; i < 6; i++) pl[i] = 8'(8'hA0 + i);
        run_frame(6, 6);
        wait_frames(f0 + 1);
        if (last_frame.size() >= 42) begin
            chk("t5_ip_id_restart", {last_frame[18], last_frame[19]}, 16'h0000);
        end

        // 6: len=1
        pl[0] = 8'h5A;
        f0 = frames_done;
        run_frame(1, 1);
        wait_frames(f0 + 1);
        chk("t6_frame_len", last_frame.size(), T6_LEN);
        if (last_frame.size() >= 43) begin
            chk("t6_udp_len", {last_frame[38], last_frame[39]}, 16'h0009);
            chk("t6_payload", last_frame[42], 8'h5A);
        end

        chk("expected_bytes_drained", exp_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
